// File: rtl/lut_row_streamer_if.sv
// Valid/ready word stream from the LUT row streamer toward the NoC injection packetizer.
interface lut_row_streamer_if #(
  parameter int RAM_WIDTH = 16,
  parameter int DEST_BITS = 4
);
  logic                 out_valid;
  logic                 out_ready;
  logic [RAM_WIDTH-1:0] out_data;
  logic [DEST_BITS-1:0] out_dest;
  logic                 out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_dest,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_dest,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/lut_row_streamer.sv
// Sweeps a contiguous LUT address range and streams the returned words,
// absorbing the 1-cycle read latency and downstream backpressure in a 2-entry FIFO.
module lut_row_streamer #(
  parameter int RAM_WIDTH     = 16,
  parameter int RAM_ADDR_BITS = 8,
  parameter int DEST_BITS     = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [RAM_ADDR_BITS-1:0] start_base,
  input  logic [RAM_ADDR_BITS:0]   start_len,
  input  logic [DEST_BITS-1:0]     start_dest,
  output logic                     busy,
  output logic                     done,
  output logic [RAM_ADDR_BITS-1:0] lut_address,
  output logic                     lut_write_enable,
  input  logic [RAM_WIDTH-1:0]     lut_rdata,
  lut_row_streamer_if.master       stream
);

  localparam int CW = RAM_ADDR_BITS + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t state_q, state_d;

  logic [RAM_ADDR_BITS-1:0] base_q;
  logic [CW-1:0]            len_q;
  logic [CW-1:0]            issued_q;
  logic [DEST_BITS-1:0]     dest_q;
  logic [RAM_ADDR_BITS-1:0] addr_q;
  logic                     inflight_q;
  logic                     inflight_last_q;
  logic                     done_q;

  logic [RAM_WIDTH-1:0]     head_data_q, tail_data_q;
  logic                     head_last_q, tail_last_q;
  logic [1:0]               count_q;

  logic       accept_start;
  logic       zero_start;
  logic       issue;
  logic       last_issue;
  logic       final_pop;
  logic       push;
  logic       pop;
  logic [2:0] occupancy;

  assign push       = inflight_q;
  assign pop        = stream.out_valid & stream.out_ready;
  assign last_issue = (issued_q == (len_q - CW'(1)));

  // A word leaving this cycle frees its slot in time for a read issued now,
  // which is what allows one word per cycle with a 2-entry FIFO.
  assign occupancy = 3'(count_q) + 3'(inflight_q) - 3'(pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    accept_start = 1'b0;
    zero_start   = 1'b0;
    issue        = 1'b0;
    final_pop    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (start_len != '0) begin
            accept_start = 1'b1;
            state_d      = RUN;
          end else begin
            zero_start = 1'b1;
          end
        end
      end
      RUN: begin
        if (occupancy < 3'd2) begin
          issue = 1'b1;
          if (last_issue) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (pop && head_last_q) begin
          final_pop = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    lut_address = addr_q;
    if (issue) begin
      lut_address = base_q + issued_q[RAM_ADDR_BITS-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q          <= '0;
      len_q           <= '0;
      issued_q        <= '0;
      dest_q          <= '0;
      addr_q          <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      done_q          <= final_pop | zero_start;
      addr_q          <= lut_address;
      inflight_q      <= issue;
      inflight_last_q <= issue & last_issue;
      if (accept_start) begin
        base_q   <= start_base;
        len_q    <= start_len;
        dest_q   <= start_dest;
        issued_q <= '0;
      end else if (issue) begin
        issued_q <= issued_q + CW'(1);
      end
    end
  end

  // Head register feeds the outputs directly; the tail slides forward on a pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_data_q <= '0;
      head_last_q <= 1'b0;
      tail_data_q <= '0;
      tail_last_q <= 1'b0;
      count_q     <= '0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) begin
            head_data_q <= lut_rdata;
            head_last_q <= inflight_last_q;
          end else begin
            tail_data_q <= lut_rdata;
            tail_last_q <= inflight_last_q;
          end
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          head_data_q <= tail_data_q;
          head_last_q <= tail_last_q;
          count_q     <= count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            head_data_q <= lut_rdata;
            head_last_q <= inflight_last_q;
          end else begin
            head_data_q <= tail_data_q;
            head_last_q <= tail_last_q;
            tail_data_q <= lut_rdata;
            tail_last_q <= inflight_last_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign stream.out_valid = (count_q != 2'd0);
  assign stream.out_data  = head_data_q;
  assign stream.out_last  = head_last_q;
  assign stream.out_dest  = dest_q;

  assign busy             = (state_q != IDLE);
  assign done             = done_q;
  assign lut_write_enable = 1'b0;

  no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && (count_q == 2'd2)));

  done_not_busy: assert property (@(posedge clk) disable iff (rst)
    !(done && busy));

endmodule

// File: tb/tb_lut_row_streamer.sv
// Randomized scoreboard bench for lut_row_streamer with directed timing, wrap, stall and reset checks.
module tb_lut_row_streamer;

  localparam int W  = 16;
  localparam int AB = 8;
  localparam int DB = 4;

  typedef struct {
    logic [W-1:0]  data;
    logic [DB-1:0] dest;
    logic          last;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AB-1:0] start_base;
  logic [AB:0]   start_len;
  logic [DB-1:0] start_dest;
  logic          busy;
  logic          done;
  logic [AB-1:0] lut_address;
  logic          lut_write_enable;
  logic [W-1:0]  lut_rdata;

  logic          ready_mode;
  logic          ready_fixed;
  logic          rand_bit;

  logic [W-1:0]  mem [256];
  exp_t          exp_q [$];
  int            pass_cnt = 0;
  int            total_cnt = 0;

  lut_row_streamer_if #(.RAM_WIDTH(W), .DEST_BITS(DB)) sif ();

  lut_row_streamer #(
    .RAM_WIDTH    (W),
    .RAM_ADDR_BITS(AB),
    .DEST_BITS    (DB)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .start_base      (start_base),
    .start_len       (start_len),
    .start_dest      (start_dest),
    .busy            (busy),
    .done            (done),
    .lut_address     (lut_address),
    .lut_write_enable(lut_write_enable),
    .lut_rdata       (lut_rdata),
    .stream          (sif.master)
  );

  always #5 clk = ~clk;

  // Registered-read LUT with one cycle of latency
  always @(posedge clk) lut_rdata <= mem[lut_address];

  assign sif.out_ready = ready_mode ? rand_bit : ready_fixed;

  initial begin
    rand_bit = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rand_bit = 1'($urandom_range(0, 1));
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
  endtask

  // Monitor: pops the scoreboard on every accepted word
  initial begin
    logic        stalled;
    logic [20:0] held;
    exp_t        e;
    stalled = 1'b0;
    held    = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stalled = 1'b0;
      end else begin
        if (stalled)
          check("hold_stable", {sif.out_data, sif.out_dest, sif.out_last}, held);
        if (sif.out_valid && sif.out_ready) begin
          if (exp_q.size() == 0) begin
            total_cnt++;
            $display("FAIL unexpected_word: got %0h expected none at %0t", sif.out_data, $time);
          end else begin
            e = exp_q.pop_front();
            check("word_data", sif.out_data, e.data);
            check("word_dest", sif.out_dest, e.dest);
            check("word_last", sif.out_last, e.last);
          end
        end
        if (done) check("done_busy_excl", busy, 0);
        stalled = sif.out_valid && !sif.out_ready;
        held    = {sif.out_data, sif.out_dest, sif.out_last};
      end
    end
  end

  // Issues a command at the next edge; returns #1 into cycle 1
  task automatic send_cmd(input logic [AB-1:0] base, input logic [AB:0] len, input logic [DB-1:0] dest);
    exp_t e;
    logic [AB-1:0] a;
    start      = 1'b1;
    start_base = base;
    start_len  = len;
    start_dest = dest;
    for (int i = 0; i < int'(len); i++) begin
      a      = base + AB'(i);
      e.data = mem[a];
      e.dest = dest;
      e.last = (i == int'(len) - 1);
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, input string name);
    logic seen;
    seen = 1'b0;
    for (int n = 0; n < limit && !seen; n++) begin
      @(negedge clk);
      seen = done;
    end
    check(name, seen, 1);
    check("queue_empty", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy"},  busy, 0);
    check({tag, "_done"},  done, 0);
    check({tag, "_valid"}, sif.out_valid, 0);
    check({tag, "_data"},  sif.out_data, 0);
    check({tag, "_dest"},  sif.out_dest, 0);
    check({tag, "_last"},  sif.out_last, 0);
    check({tag, "_addr"},  lut_address, 0);
    check({tag, "_we"},    lut_write_enable, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = W'($urandom);
    rst         = 1'b1;
    start       = 1'b0;
    start_base  = '0;
    start_len   = '0;
    start_dest  = '0;
    ready_mode  = 1'b0;
    ready_fixed = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic timing: addresses 10..13 in cycles 1-4, valid 3-6, done in 7
    send_cmd(8'h10, 9'd4, 4'd3);
    for (int cyc = 1; cyc <= 7; cyc++) begin
      @(negedge clk);
      if (cyc <= 4) check("t1_addr", lut_address, 32'(8'h10 + cyc - 1));
      check("t1_valid", sif.out_valid, (cyc >= 3 && cyc <= 6));
      check("t1_done",  done, (cyc == 7));
      check("t1_busy",  busy, (cyc <= 6));
      @(posedge clk);
      #1;
    end
    check("t1_queue_empty", exp_q.size(), 0);

    // Stall with out_ready low in cycles 3-8
    send_cmd(8'h10, 9'd4, 4'd3);
    for (int cyc = 1; cyc <= 8; cyc++) begin
      ready_fixed = !(cyc >= 3 && cyc <= 8);
      @(negedge clk);
      if (cyc >= 2) check("t2_addr_bound", (lut_address <= 8'h11), 1);
      @(posedge clk);
      #1;
    end
    ready_fixed = 1'b1;
    wait_done(40, "t2_done");

    // Address wrap FE,FF,00,01
    send_cmd(8'hFE, 9'd4, 4'd5);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t3_wrap_addr", lut_address, 32'(8'(8'hFE + k)));
      @(posedge clk);
      #1;
    end
    wait_done(40, "t3_done");

    // Zero-length command
    send_cmd(8'h20, 9'd0, 4'd1);
    @(negedge clk);
    check("t4_done_pulse", done, 1);
    check("t4_busy", busy, 0);
    check("t4_valid", sif.out_valid, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("t4_done_single", done, 0);
    check("t4_busy2", busy, 0);
    @(posedge clk);
    #1;

    // Whole LUT with random backpressure
    ready_mode = 1'b1;
    send_cmd(8'h00, 9'd256, 4'hA);
    wait_done(3000, "t5_done");

    // Random commands under random backpressure
    for (int r = 0; r < 6; r++) begin
      send_cmd(AB'($urandom), 9'($urandom_range(1, 20)), DB'($urandom));
      wait_done(200, "rand_done");
    end
    ready_mode = 1'b0;

    // Second start while busy is ignored
    send_cmd(8'h40, 9'd6, 4'd2);
    start      = 1'b1;
    start_base = 8'h80;
    start_len  = 9'd3;
    start_dest = 4'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(40, "t6_done");

    // Reset in cycle 4 of a len=8 command
    send_cmd(8'h50, 9'd8, 4'd9);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    #1;
    check_zero_outputs("abort");
    exp_q.delete();
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    send_cmd(8'h60, 9'd3, 4'd6);
    wait_done(40, "t7_done");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
